// File: rtl/obf_seq_ctrl_if.sv
// Fetch / generator / decode signal bundle for the obfuscated instruction sequencer.
interface obf_seq_ctrl_if #(
  parameter int unsigned PPC_WIDTH = 3,
  parameter int unsigned KEY_WIDTH = 8
);
  logic [31:0]          ref_insn_i;
  logic                 ref_valid_i;
  logic                 ref_ready_o;
  logic                 flush_i;
  logic                 en_i;
  logic [KEY_WIDTH-1:0] key_i;
  logic                 key_we_i;
  logic [31:0]          gen_insn_i;
  logic                 gen_last_i;
  logic                 gen_skip_i;
  logic [31:0]          gen_ref_o;
  logic [PPC_WIDTH-1:0] gen_ppc_o;
  logic [KEY_WIDTH-1:0] gen_key_o;
  logic                 gen_en_o;
  logic [31:0]          obf_insn_o;
  logic                 obf_valid_o;
  logic                 obf_ready_i;
  logic                 obf_first_o;
  logic                 seq_err_o;

  // Environment side: fetch, generator and decode.
  modport master (
    output ref_insn_i, ref_valid_i, flush_i, en_i, key_i, key_we_i,
           gen_insn_i, gen_last_i, gen_skip_i, obf_ready_i,
    input  ref_ready_o, gen_ref_o, gen_ppc_o, gen_key_o, gen_en_o,
           obf_insn_o, obf_valid_o, obf_first_o, seq_err_o
  );

  // Controller side.
  modport slave (
    input  ref_insn_i, ref_valid_i, flush_i, en_i, key_i, key_we_i,
           gen_insn_i, gen_last_i, gen_skip_i, obf_ready_i,
    output ref_ready_o, gen_ref_o, gen_ppc_o, gen_key_o, gen_en_o,
           obf_insn_o, obf_valid_o, obf_first_o, seq_err_o
  );
endinterface

// File: rtl/obf_seq_ctrl.sv
// Obfuscated instruction sequencer: captures a fetch word, steps the substitution
// index through the generator's sequence and streams each word to decode.
module obf_seq_ctrl #(
  parameter int unsigned PPC_WIDTH = 3,
  parameter int unsigned KEY_WIDTH = 8
) (
  input logic           clk,
  input logic           rst,
  obf_seq_ctrl_if.slave bus
);

  typedef enum logic {IDLE, RUN} state_t;

  localparam logic [PPC_WIDTH:0] PPC_MAX = {1'b0, {PPC_WIDTH{1'b1}}};

  state_t               state, state_nxt;
  logic [PPC_WIDTH-1:0] ppc_q, ppc_nxt;
  logic [PPC_WIDTH:0]   ppc_sum;
  logic [31:0]          ref_q;
  logic [KEY_WIDTH-1:0] key_q, key_pend;
  logic                 key_pend_vld;
  logic                 en_q;
  logic                 err_q;
  logic                 capture;
  logic                 err_set;
  logic                 ref_ready;
  logic                 obf_valid;

  // Next-state, index stepping and handshake decode; flush overrides everything.
  always_comb begin
    state_nxt = state;
    ppc_nxt   = ppc_q;
    capture   = 1'b0;
    err_set   = 1'b0;
    ref_ready = 1'b0;
    obf_valid = 1'b0;
    ppc_sum   = {1'b0, ppc_q} + (bus.gen_skip_i ? (PPC_WIDTH+1)'(2) : (PPC_WIDTH+1)'(1));
    if (bus.flush_i) begin
      state_nxt = IDLE;
      ppc_nxt   = '0;
    end else begin
      case (state)
        IDLE: begin
          ref_ready = 1'b1;
          if (bus.ref_valid_i) begin
            capture   = 1'b1;
            state_nxt = RUN;
            ppc_nxt   = '0;
          end
        end
        RUN: begin
          obf_valid = 1'b1;
          ref_ready = bus.gen_last_i & bus.obf_ready_i;
          if (bus.obf_ready_i) begin
            if (bus.gen_last_i) begin
              ppc_nxt = '0;
              if (bus.ref_valid_i) capture = 1'b1;
              else state_nxt = IDLE;
            end else if (ppc_sum > PPC_MAX) begin
              err_set   = 1'b1;
              state_nxt = IDLE;
              ppc_nxt   = '0;
            end else begin
              ppc_nxt = ppc_sum[PPC_WIDTH-1:0];
            end
          end
        end
        default: state_nxt = IDLE;
      endcase
    end
  end

  // State and substitution index registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      ppc_q <= '0;
    end else begin
      state <= state_nxt;
      ppc_q <= ppc_nxt;
    end
  end

  // Captured instruction, enable, key staging and sticky overrun flag.
  // A key write in the capture cycle bypasses the pending slot so it wins.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ref_q        <= '0;
      en_q         <= 1'b0;
      key_q        <= '0;
      key_pend     <= '0;
      key_pend_vld <= 1'b0;
      err_q        <= 1'b0;
    end else begin
      if (bus.key_we_i) key_pend <= bus.key_i;
      if (capture) begin
        ref_q        <= bus.ref_insn_i;
        en_q         <= bus.en_i;
        key_pend_vld <= 1'b0;
        if (bus.key_we_i) key_q <= bus.key_i;
        else if (key_pend_vld) key_q <= key_pend;
      end else if (bus.key_we_i) begin
        key_pend_vld <= 1'b1;
      end
      if (err_set) err_q <= 1'b1;
    end
  end

  assign bus.ref_ready_o = ref_ready & ~rst;
  assign bus.obf_valid_o = obf_valid & ~rst;
  assign bus.obf_insn_o  = bus.gen_insn_i;
  assign bus.obf_first_o = (ppc_q == '0);
  assign bus.gen_ref_o   = ref_q;
  assign bus.gen_ppc_o   = ppc_q;
  assign bus.gen_key_o   = key_q;
  assign bus.gen_en_o    = en_q;
  assign bus.seq_err_o   = err_q;

endmodule

// File: tb/tb_obf_seq_ctrl.sv
// Bench for obf_seq_ctrl. A generator stub decodes sequence shape from the captured
// reference word: [2:0] last ppc, [5:3] skip slot, [6] skip enable, [7] never last.
module tb_obf_seq_ctrl;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_vec = 0;
  int   n_err = 0;

  always #5 clk = ~clk;

  obf_seq_ctrl_if #(.PPC_WIDTH(3), .KEY_WIDTH(8)) bus ();

  obf_seq_ctrl #(.PPC_WIDTH(3), .KEY_WIDTH(8)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  function automatic logic [31:0] gen_word(logic [31:0] r, logic [7:0] k, logic e, logic [2:0] p);
    return e ? (r ^ {p, 21'h0, k}) : r;
  endfunction

  always_comb begin
    bus.gen_last_i = bus.gen_en_o ? (!bus.gen_ref_o[7] && bus.gen_ppc_o == bus.gen_ref_o[2:0])
                                  : (bus.gen_ppc_o == 3'd0);
    bus.gen_skip_i = bus.gen_en_o && bus.gen_ref_o[6] && (bus.gen_ppc_o == bus.gen_ref_o[5:3]);
    bus.gen_insn_i = gen_word(bus.gen_ref_o, bus.gen_key_o, bus.gen_en_o, bus.gen_ppc_o);
  end

  typedef struct {
    logic [2:0]  ppc;
    logic [31:0] word;
    logic [7:0]  key;
    bit          last;
  } exp_t;

  exp_t exp_q[$];

  task automatic cyc();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic drive_idle();
    bus.ref_insn_i  = '0;
    bus.ref_valid_i = 1'b0;
    bus.flush_i     = 1'b0;
    bus.en_i        = 1'b0;
    bus.key_i       = '0;
    bus.key_we_i    = 1'b0;
    bus.obf_ready_i = 1'b1;
  endtask

  task automatic test_reset();
    drive_idle();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    #1;
    n_vec++; if (bus.ref_ready_o !== 1'b1) begin n_err++; $display("FAIL rst_ref_ready: got %b want 1", bus.ref_ready_o); end
    n_vec++; if (bus.obf_valid_o !== 1'b0) begin n_err++; $display("FAIL rst_obf_valid: got %b want 0", bus.obf_valid_o); end
    n_vec++; if (bus.gen_ppc_o !== 3'd0) begin n_err++; $display("FAIL rst_ppc: got %0d want 0", bus.gen_ppc_o); end
    n_vec++; if (bus.gen_key_o !== 8'h00) begin n_err++; $display("FAIL rst_key: got %h want 00", bus.gen_key_o); end
    n_vec++; if (bus.gen_ref_o !== 32'h0) begin n_err++; $display("FAIL rst_ref: got %h want 0", bus.gen_ref_o); end
    n_vec++; if (bus.gen_en_o !== 1'b0) begin n_err++; $display("FAIL rst_en: got %b want 0", bus.gen_en_o); end
    n_vec++; if (bus.seq_err_o !== 1'b0) begin n_err++; $display("FAIL rst_err: got %b want 0", bus.seq_err_o); end
  endtask

  task automatic test_passthrough();
    bus.ref_insn_i  = 32'hE0611800;
    bus.ref_valid_i = 1'b1;
    bus.en_i        = 1'b0;
    #1;
    n_vec++; if (bus.ref_ready_o !== 1'b1) begin n_err++; $display("FAIL pt_accept: got %b want 1", bus.ref_ready_o); end
    cyc();
    bus.ref_valid_i = 1'b0;
    #1;
    n_vec++; if (bus.obf_valid_o !== 1'b1) begin n_err++; $display("FAIL pt_valid: got %b want 1", bus.obf_valid_o); end
    n_vec++; if (bus.obf_insn_o !== 32'hE0611800) begin n_err++; $display("FAIL pt_insn: got %h want E0611800", bus.obf_insn_o); end
    n_vec++; if (bus.obf_first_o !== 1'b1) begin n_err++; $display("FAIL pt_first: got %b want 1", bus.obf_first_o); end
    n_vec++; if (bus.gen_en_o !== 1'b0) begin n_err++; $display("FAIL pt_en: got %b want 0", bus.gen_en_o); end
    cyc();
    #1;
    n_vec++; if (bus.obf_valid_o !== 1'b0) begin n_err++; $display("FAIL pt_idle: got %b want 0", bus.obf_valid_o); end
  endtask

  task automatic test_lut_sequence();
    logic [31:0] r;
    r = 32'h12345602;
    bus.ref_insn_i  = r;
    bus.ref_valid_i = 1'b1;
    bus.en_i        = 1'b1;
    cyc();
    bus.ref_valid_i = 1'b0;
    for (int k = 0; k < 3; k++) begin
      #1;
      n_vec++; if (bus.obf_valid_o !== 1'b1) begin n_err++; $display("FAIL lut_valid[%0d]: got %b want 1", k, bus.obf_valid_o); end
      n_vec++; if (bus.gen_ppc_o !== 3'(k)) begin n_err++; $display("FAIL lut_ppc[%0d]: got %0d want %0d", k, bus.gen_ppc_o, k); end
      n_vec++; if (bus.obf_insn_o !== gen_word(r, 8'h00, 1'b1, 3'(k))) begin n_err++; $display("FAIL lut_insn[%0d]: got %h want %h", k, bus.obf_insn_o, gen_word(r, 8'h00, 1'b1, 3'(k))); end
      n_vec++; if (bus.ref_ready_o !== (k == 2)) begin n_err++; $display("FAIL lut_ref_ready[%0d]: got %b want %b", k, bus.ref_ready_o, k == 2); end
      cyc();
    end
    #1;
    n_vec++; if (bus.obf_valid_o !== 1'b0) begin n_err++; $display("FAIL lut_idle: got %b want 0", bus.obf_valid_o); end
  endtask

  task automatic test_skip();
    int exp_ppc[3] = '{0, 1, 3};
    bus.ref_insn_i  = 32'hA5A5A54B;
    bus.ref_valid_i = 1'b1;
    bus.en_i        = 1'b1;
    cyc();
    bus.ref_valid_i = 1'b0;
    for (int k = 0; k < 3; k++) begin
      #1;
      n_vec++; if (bus.gen_ppc_o !== 3'(exp_ppc[k]) || bus.obf_valid_o !== 1'b1) begin n_err++; $display("FAIL skip_ppc[%0d]: got %0d/v%b want %0d/v1", k, bus.gen_ppc_o, bus.obf_valid_o, exp_ppc[k]); end
      cyc();
    end
    #1;
    n_vec++; if (bus.obf_valid_o !== 1'b0) begin n_err++; $display("FAIL skip_idle: got %b want 0", bus.obf_valid_o); end
  endtask

  task automatic test_stall();
    logic [31:0] r;
    r = 32'h0BADF002;
    bus.ref_insn_i  = r;
    bus.ref_valid_i = 1'b1;
    bus.en_i        = 1'b1;
    cyc();
    bus.ref_valid_i = 1'b0;
    cyc();
    bus.obf_ready_i = 1'b0;
    bus.ref_valid_i = 1'b1;
    bus.ref_insn_i  = 32'hDEAD0000;
    for (int k = 0; k < 4; k++) begin
      #1;
      n_vec++; if (bus.gen_ppc_o !== 3'd1 || bus.obf_insn_o !== gen_word(r, 8'h00, 1'b1, 3'd1)) begin n_err++; $display("FAIL stall_hold[%0d]: got ppc %0d insn %h want ppc 1 insn %h", k, bus.gen_ppc_o, bus.obf_insn_o, gen_word(r, 8'h00, 1'b1, 3'd1)); end
      n_vec++; if (bus.ref_ready_o !== 1'b0 || bus.obf_valid_o !== 1'b1) begin n_err++; $display("FAIL stall_hs[%0d]: got ready %b valid %b want 0/1", k, bus.ref_ready_o, bus.obf_valid_o); end
      cyc();
    end
    bus.obf_ready_i = 1'b1;
    bus.ref_valid_i = 1'b0;
    cyc();
    #1;
    n_vec++; if (bus.gen_ppc_o !== 3'd2 || bus.ref_ready_o !== 1'b1) begin n_err++; $display("FAIL stall_resume: got ppc %0d ready %b want 2/1", bus.gen_ppc_o, bus.ref_ready_o); end
    cyc();
  endtask

  task automatic test_flush();
    logic [31:0] r;
    bus.ref_insn_i  = 32'hCAFE0002;
    bus.ref_valid_i = 1'b1;
    bus.en_i        = 1'b1;
    cyc();
    bus.ref_valid_i = 1'b0;
    cyc();
    bus.flush_i     = 1'b1;
    bus.ref_valid_i = 1'b1;
    bus.ref_insn_i  = 32'h99990001;
    #1;
    n_vec++; if (bus.obf_valid_o !== 1'b0 || bus.ref_ready_o !== 1'b0) begin n_err++; $display("FAIL flush_same: got valid %b ready %b want 0/0", bus.obf_valid_o, bus.ref_ready_o); end
    cyc();
    bus.flush_i     = 1'b0;
    bus.ref_valid_i = 1'b0;
    #1;
    n_vec++; if (bus.obf_valid_o !== 1'b0 || bus.ref_ready_o !== 1'b1 || bus.gen_ppc_o !== 3'd0) begin n_err++; $display("FAIL flush_idle: got valid %b ready %b ppc %0d want 0/1/0", bus.obf_valid_o, bus.ref_ready_o, bus.gen_ppc_o); end
    r = 32'h11110001;
    bus.ref_insn_i  = r;
    bus.ref_valid_i = 1'b1;
    cyc();
    bus.ref_valid_i = 1'b0;
    #1;
    n_vec++; if (bus.gen_ppc_o !== 3'd0 || bus.obf_insn_o !== gen_word(r, 8'h00, 1'b1, 3'd0)) begin n_err++; $display("FAIL flush_restart: got ppc %0d insn %h want 0 %h", bus.gen_ppc_o, bus.obf_insn_o, gen_word(r, 8'h00, 1'b1, 3'd0)); end
    repeat (2) cyc();
  endtask

  task automatic test_key();
    bus.key_we_i = 1'b1;
    bus.key_i    = 8'h3C;
    cyc();
    bus.key_we_i    = 1'b0;
    bus.ref_insn_i  = 32'h00AA0002;
    bus.ref_valid_i = 1'b1;
    bus.en_i        = 1'b1;
    cyc();
    bus.ref_valid_i = 1'b0;
    bus.key_we_i    = 1'b1;
    bus.key_i       = 8'h5A;
    for (int k = 0; k < 3; k++) begin
      #1;
      n_vec++; if (bus.gen_key_o !== 8'h3C) begin n_err++; $display("FAIL key_hold[%0d]: got %h want 3C", k, bus.gen_key_o); end
      if (k == 2) begin
        bus.ref_insn_i  = 32'h00BB0000;
        bus.ref_valid_i = 1'b1;
      end
      cyc();
      bus.key_we_i = 1'b0;
    end
    bus.ref_valid_i = 1'b0;
    #1;
    n_vec++; if (bus.gen_key_o !== 8'h5A || bus.obf_valid_o !== 1'b1 || bus.gen_ppc_o !== 3'd0) begin n_err++; $display("FAIL key_b2b: got key %h valid %b ppc %0d want 5A/1/0", bus.gen_key_o, bus.obf_valid_o, bus.gen_ppc_o); end
    n_vec++; if (bus.obf_insn_o !== gen_word(32'h00BB0000, 8'h5A, 1'b1, 3'd0)) begin n_err++; $display("FAIL key_b2b_insn: got %h want %h", bus.obf_insn_o, gen_word(32'h00BB0000, 8'h5A, 1'b1, 3'd0)); end
    cyc();
    bus.ref_insn_i  = 32'h00CC0000;
    bus.ref_valid_i = 1'b1;
    bus.key_we_i    = 1'b1;
    bus.key_i       = 8'h77;
    cyc();
    bus.ref_valid_i = 1'b0;
    bus.key_we_i    = 1'b0;
    #1;
    n_vec++; if (bus.gen_key_o !== 8'h77) begin n_err++; $display("FAIL key_same_cycle: got %h want 77", bus.gen_key_o); end
    cyc();
  endtask

  task automatic test_overrun();
    bus.ref_insn_i  = 32'h00000080;
    bus.ref_valid_i = 1'b1;
    bus.en_i        = 1'b1;
    cyc();
    bus.ref_valid_i = 1'b0;
    for (int k = 0; k < 8; k++) begin
      #1;
      n_vec++; if (bus.gen_ppc_o !== 3'(k) || bus.seq_err_o !== 1'b0 || bus.obf_valid_o !== 1'b1) begin n_err++; $display("FAIL ovr_step[%0d]: got ppc %0d err %b valid %b want %0d/0/1", k, bus.gen_ppc_o, bus.seq_err_o, bus.obf_valid_o, k); end
      cyc();
    end
    #1;
    n_vec++; if (bus.seq_err_o !== 1'b1 || bus.obf_valid_o !== 1'b0) begin n_err++; $display("FAIL ovr_err: got err %b valid %b want 1/0", bus.seq_err_o, bus.obf_valid_o); end
    bus.ref_insn_i  = 32'h00000000;
    bus.ref_valid_i = 1'b1;
    cyc();
    bus.ref_valid_i = 1'b0;
    cyc();
    #1;
    n_vec++; if (bus.seq_err_o !== 1'b1) begin n_err++; $display("FAIL ovr_sticky: got %b want 1", bus.seq_err_o); end
  endtask

  task automatic test_reset_mid();
    bus.ref_insn_i  = 32'h55550002;
    bus.ref_valid_i = 1'b1;
    bus.en_i        = 1'b1;
    cyc();
    bus.ref_valid_i = 1'b0;
    cyc();
    rst = 1'b1;
    #1;
    n_vec++; if (bus.obf_valid_o !== 1'b0 || bus.gen_ppc_o !== 3'd0 || bus.seq_err_o !== 1'b0) begin n_err++; $display("FAIL rstmid: got valid %b ppc %0d err %b want 0/0/0", bus.obf_valid_o, bus.gen_ppc_o, bus.seq_err_o); end
    cyc();
    rst = 1'b0;
    #1;
    n_vec++; if (bus.ref_ready_o !== 1'b1 || bus.gen_en_o !== 1'b0) begin n_err++; $display("FAIL rstmid_idle: got ready %b en %b want 1/0", bus.ref_ready_o, bus.gen_en_o); end
  endtask

  task automatic test_random();
    int          issued = 0;
    int          cycles = 0;
    logic [7:0]  last_key = 8'h00;
    logic [7:0]  cap_key;
    bit          exp_valid, exp_ready;
    int unsigned l, s, sk, p;
    logic [31:0] r;
    exp_q.delete();
    while (issued < 40 || exp_q.size() != 0) begin
      if (cycles >= 3000) begin
        n_vec++; n_err++;
        $display("FAIL rnd_timeout: got %0d issued %0d queued want all drained", issued, exp_q.size());
        break;
      end
      cycles++;
      l  = $urandom_range(0, 6);
      sk = (l >= 2) ? $urandom_range(0, 1) : 0;
      s  = (l >= 2) ? $urandom_range(0, l - 2) : 0;
      bus.ref_insn_i  = {$urandom_range(0, 32'hFFFFFF), 1'b0, sk[0], s[2:0], l[2:0]};
      bus.ref_valid_i = (issued < 40) && ($urandom_range(0, 3) != 0);
      bus.en_i        = $urandom_range(0, 1);
      bus.obf_ready_i = ($urandom_range(0, 3) != 0);
      bus.key_we_i    = ($urandom_range(0, 4) == 0);
      bus.key_i       = $urandom_range(0, 255);
      #1;
      exp_valid = (exp_q.size() != 0);
      exp_ready = !exp_valid || (exp_q[0].last && bus.obf_ready_i);
      n_vec++; if (bus.obf_valid_o !== exp_valid) begin n_err++; $display("FAIL rnd_valid@%0d: got %b want %b", cycles, bus.obf_valid_o, exp_valid); end
      n_vec++; if (bus.ref_ready_o !== exp_ready) begin n_err++; $display("FAIL rnd_ready@%0d: got %b want %b", cycles, bus.ref_ready_o, exp_ready); end
      if (exp_valid) begin
        n_vec++; if (bus.obf_insn_o !== exp_q[0].word || bus.gen_ppc_o !== exp_q[0].ppc) begin n_err++; $display("FAIL rnd_word@%0d: got %h ppc %0d want %h ppc %0d", cycles, bus.obf_insn_o, bus.gen_ppc_o, exp_q[0].word, exp_q[0].ppc); end
        n_vec++; if (bus.gen_key_o !== exp_q[0].key || bus.obf_first_o !== (exp_q[0].ppc == 3'd0)) begin n_err++; $display("FAIL rnd_key@%0d: got key %h first %b want %h %b", cycles, bus.gen_key_o, bus.obf_first_o, exp_q[0].key, exp_q[0].ppc == 3'd0); end
        if (bus.obf_ready_i) void'(exp_q.pop_front());
      end
      cap_key = bus.key_we_i ? bus.key_i : last_key;
      if (exp_ready && bus.ref_valid_i) begin
        r = bus.ref_insn_i;
        if (!bus.en_i) begin
          exp_q.push_back('{ppc: 3'd0, word: r, key: cap_key, last: 1'b1});
        end else begin
          p = 0;
          while (1) begin
            exp_q.push_back('{ppc: 3'(p), word: gen_word(r, cap_key, 1'b1, 3'(p)), key: cap_key, last: (p == l)});
            if (p == l) break;
            p = p + ((sk != 0 && p == s) ? 2 : 1);
          end
        end
        issued++;
      end
      if (bus.key_we_i) last_key = bus.key_i;
      cyc();
    end
    drive_idle();
  endtask

  initial begin
    test_reset();
    test_passthrough();
    test_lut_sequence();
    test_skip();
    test_stall();
    test_flush();
    test_key();
    test_overrun();
    test_reset_mid();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
